pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
// Program counter / fetch sequencer: consumes branch enables, target index and Ack from the
// control decoder and produces the instruction ROM address each cycle. Owns run/halt
// sequencing (Start -> run -> Done) and a cycle counter used by the testbench scoreboard.
// Sits between the control decoder (upstream, combinational) and instrROM (downstream).
// PARAMETERS
// PC_W       10     program counter / ROM address width
// LUT_DEPTH  32     branch-offset LUT entries, indexed by PCTarg[4:0]
// START_PC   0      PC loaded on Start
// CNT_W      16     cycle counter width
// PORTS
// Clk        in   1      clock; single clock domain
// Reset      in   1      synchronous, active-high; dominates all other inputs
// Start      in   1      level/pulse; sampled only in IDLE or HALT
// BaddEn     in   1      forward relative branch request (from decoder)
// BsubEn     in   1      backward relative branch request (from decoder)
// CondFlag   in   1      branch condition from ALU (registered CMP result)
// Ack        in   1      STOP decoded; end of program
// PCTarg     in   PC_W   branch target field; bits [4:0] index the offset LUT
// ProgCtr    out  PC_W   instruction ROM address
// Running    out  1      high while state==RUN
// Done       out  1      high while state==HALT
// CycleCnt   out  CNT_W  cycles spent in RUN for the current/last program
// BEHAVIOUR
// - Reset (sync, high): state=IDLE, ProgCtr=START_PC, Running=0, Done=0, CycleCnt=0.
// - States: IDLE -(Start)-> RUN; RUN -(Ack)-> HALT; HALT -(Start)-> RUN; else hold.
// - Entering RUN: ProgCtr<=START_PC, CycleCnt<=0, Done<=0 on the same edge.
// - In RUN, one update per cycle, priority order:
//   1. Ack=1: ProgCtr holds, next state HALT, branch enables ignored.
//   2. BaddEn^BsubEn and CondFlag=1: offs=LUT[PCTarg[4:0]];
//      BaddEn -> ProgCtr<=ProgCtr+offs; BsubEn -> ProgCtr<=ProgCtr-offs.
//   3. Otherwise (incl. BaddEn&BsubEn both high, or CondFlag=0): ProgCtr<=ProgCtr+1.
// - Arithmetic mod 2^PC_W: ProgCtr=1023 +1 -> 0; Bsub underflow wraps likewise.
// - Offset of 0 from LUT is legal: branch to self (hang until Ack/Reset).
// - CycleCnt increments every RUN cycle incl. the Ack cycle; saturates at 2^CNT_W-1.
// - Start in RUN ignored. Start and Ack same cycle in RUN: Ack wins; Start must be re-sampled in HALT.
// - Running/Done are registered, mutually exclusive, both 0 in IDLE. Done stays high until
//   next Start or Reset. ProgCtr and CycleCnt hold value in HALT for readback.
// - Latency: input decision at edge N visible on ProgCtr after edge N (next ROM address).
// - Reset mid-RUN: next edge returns to IDLE with all reset values; no partial state kept.
// STRUCTURE
// - definitions package: add fetch_state_t enum {IDLE, RUN, HALT}, PC_W/LUT_DEPTH constants.
// - Sub-module branch_lut: combinational 32 x PC_W ROM, index -> offset; contents from
//   $readmemb file so program changes do not touch RTL.
// - Top: state register, ProgCtr register with next-PC mux, CycleCnt register.
// TESTING
// - Reset then Start pulse -> Running=1 next cycle, ProgCtr 0,1,2,3 on successive cycles.
// - ProgCtr=10, BaddEn=1, CondFlag=1, LUT[3]=5, PCTarg=3 -> ProgCtr=15; CondFlag=0 -> 11.
// - ProgCtr=2, BsubEn=1, CondFlag=1, LUT[0]=4 -> ProgCtr=1022 (wrap); ProgCtr=1023 seq -> 0.
// - Ack at ProgCtr=7 with BaddEn=1 -> ProgCtr stays 7, Done=1, Running=0, CycleCnt=8; then
//   Start -> ProgCtr=0, CycleCnt=0, Done=0.
// - BaddEn=BsubEn=1, CondFlag=1 at ProgCtr=20 -> ProgCtr=21.
// - Reset asserted mid-RUN at ProgCtr=50 -> next edge IDLE, ProgCtr=0, Running=Done=0;
//   Start while Running=1 -> no effect on ProgCtr sequence.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: default widths, state encoding
// and the default branch-offset table.
package pc_fetch_unit_pkg;

  localparam int unsigned DEF_PC_W      = 10;
  localparam int unsigned DEF_LUT_DEPTH = 32;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned LUT_IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Default offset table: entry i holds offset i+1. Programs supply their own
  // table through the LUT_INIT parameter of the top level.
  function automatic logic [DEF_LUT_DEPTH*DEF_PC_W-1:0] default_lut();
    logic [DEF_LUT_DEPTH*DEF_PC_W-1:0] lut;
    lut = '0;
    for (int unsigned i = 0; i < DEF_LUT_DEPTH; i++) begin
      lut[i*DEF_PC_W +: DEF_PC_W] = DEF_PC_W'(i + 1);
    end
    return lut;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_branch_lut.sv
// Combinational branch-offset ROM. Contents come in as a flattened parameter
// (entry i at bits [i*PC_W +: PC_W]) so program changes stay out of the RTL.
module pc_fetch_unit_branch_lut
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned                   PC_W      = DEF_PC_W,
  parameter int unsigned                   LUT_DEPTH = DEF_LUT_DEPTH,
  parameter logic [LUT_DEPTH*PC_W-1:0]     LUT_INIT  = default_lut()
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [PC_W-1:0]      offs
);

  always_comb begin
    offs = LUT_INIT[idx*PC_W +: PC_W];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer: run/halt control, next-PC selection with
// LUT-relative branches, and a saturating RUN-cycle counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned               PC_W      = DEF_PC_W,
  parameter int unsigned               LUT_DEPTH = DEF_LUT_DEPTH,
  parameter logic [PC_W-1:0]           START_PC  = '0,
  parameter int unsigned               CNT_W     = DEF_CNT_W,
  parameter logic [LUT_DEPTH*PC_W-1:0] LUT_INIT  = default_lut()
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BaddEn,
  input  logic             BsubEn,
  input  logic             CondFlag,
  input  logic             Ack,
  input  logic [PC_W-1:0]  PCTarg,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCnt
);

  fetch_state_t    state;
  logic [PC_W-1:0] offs;
  logic [PC_W-1:0] next_pc;
  logic            take_branch;
  logic            unused_targ;

  assign unused_targ = ^PCTarg[PC_W-1:LUT_IDX_W];

  pc_fetch_unit_branch_lut #(
    .PC_W      (PC_W),
    .LUT_DEPTH (LUT_DEPTH),
    .LUT_INIT  (LUT_INIT)
  ) u_branch_lut (
    .idx  (PCTarg[LUT_IDX_W-1:0]),
    .offs (offs)
  );

  // Both enables high is treated as "no branch" and falls through to +1.
  always_comb begin
    take_branch = (BaddEn ^ BsubEn) & CondFlag;
    next_pc     = ProgCtr + 1'b1;
    if (take_branch) begin
      next_pc = BaddEn ? (ProgCtr + offs) : (ProgCtr - offs);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ProgCtr  <= START_PC;
      Running  <= 1'b0;
      Done     <= 1'b0;
      CycleCnt <= '0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (Start) begin
            state    <= RUN;
            ProgCtr  <= START_PC;
            CycleCnt <= '0;
            Running  <= 1'b1;
            Done     <= 1'b0;
          end
        end
        RUN: begin
          if (CycleCnt != '1) begin
            CycleCnt <= CycleCnt + 1'b1;
          end
          // Ack freezes the PC so the final address stays readable in HALT.
          if (Ack) begin
            state   <= HALT;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else begin
            ProgCtr <= next_pc;
          end
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
